// File: rtl/fast_pkg.sv
// Shared types and default geometry for the FAST corner frame sequencer.
//   IMG_COL_DEF/IMG_ROW_DEF/PIXEL_WIDTH_DEF/COORD_W_DEF : default frame geometry
//   seq_state_t : sequencer state encoding
//   corner_t    : one captured corner coordinate pair {y, x}
package fast_pkg;

  localparam int unsigned IMG_COL_DEF     = 640;
  localparam int unsigned IMG_ROW_DEF     = 480;
  localparam int unsigned PIXEL_WIDTH_DEF = 8;
  localparam int unsigned COORD_W_DEF     = 10;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic [COORD_W_DEF-1:0] y;
    logic [COORD_W_DEF-1:0] x;
  } corner_t;

endpackage

// File: rtl/fast_corner_fifo.sv
// Synchronous FIFO of corner_t entries.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   flush           : empties the FIFO (contents become unreachable)
//   push, wdata     : write request and entry; ignored when full unless popping
//   pop             : remove head entry (ignored when empty)
//   head            : head entry, read combinationally from storage
//   full, empty     : status flags
//   level           : number of stored entries
module fast_corner_fifo
  import fast_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  corner_t                  wdata,
  output corner_t                  head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

  corner_t     mem [DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra pointer bit distinguishes full from empty; wraps modulo 2*DEPTH.
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (level == FULL_LVL);
  assign do_pop  = pop && !empty;
  // A pop frees the slot the write lands in, so push+pop while full is legal.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '{default: '0};
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fast_frame_sequencer.sv
// Frame-level controller for the FAST_with_NMS corner core: streams one frame
// from pixel RAM into the core, flushes the core's line buffers with zeros,
// and queues reported corners for a valid/ready consumer.
// Optional feature macro: FAST_SEQ_CORNER_CNT_EN adds corner_count[19:0].
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   start / busy / done       : frame handshake
//   mem_rd_en/mem_addr/mem_rdata : synchronous pixel RAM (1-cycle read latency)
//   core_ce/core_data         : FAST core enable and pixel
//   core_iscorner/core_x/core_y : corner report from the core
//   crn_valid/crn_ready/crn_x/crn_y : corner FIFO drain port
//   overflow                  : sticky, a corner was dropped this frame
//   corner_count              : corners offered this frame (macro only)
module fast_frame_sequencer
  import fast_pkg::*;
#(
  parameter int unsigned IMG_COL        = IMG_COL_DEF,
  parameter int unsigned IMG_ROW        = IMG_ROW_DEF,
  parameter int unsigned PIXEL_WIDTH    = PIXEL_WIDTH_DEF,
  parameter int unsigned COORD_W        = COORD_W_DEF,
  parameter int unsigned ADDR_W         = 19,
  parameter int unsigned DRAIN_CYCLES   = 4*IMG_COL+8,
  parameter int unsigned CRN_FIFO_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [PIXEL_WIDTH-1:0] mem_rdata,
  output logic                   core_ce,
  output logic [PIXEL_WIDTH-1:0] core_data,
  input  logic                   core_iscorner,
  input  logic [COORD_W-1:0]     core_x,
  input  logic [COORD_W-1:0]     core_y,
  output logic                   crn_valid,
  input  logic                   crn_ready,
  output logic [COORD_W-1:0]     crn_x,
  output logic [COORD_W-1:0]     crn_y,
  output logic                   overflow
`ifdef FAST_SEQ_CORNER_CNT_EN
  ,
  output logic [19:0]            corner_count
`endif
);

  localparam int unsigned NPIX    = IMG_COL * IMG_ROW;
  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NPIX - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(DRAIN_CYCLES);
  localparam int unsigned LVL_W   = $clog2(CRN_FIFO_DEPTH) + 1;

  seq_state_t         state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               pix_valid;
  logic               accept;
  logic               push;
  logic               pop;
  logic               drop;
  corner_t            wdata;
  corner_t            head;
  logic               crn_full;
  logic               crn_empty;
  logic [LVL_W-1:0]   crn_level;

  assign accept = (state == IDLE) && start;
  assign push   = busy && core_iscorner;
  assign pop    = !crn_empty && crn_ready;
  assign drop   = push && crn_full && !pop;
  assign wdata  = '{y: COORD_W_DEF'(core_y), x: COORD_W_DEF'(core_x)};

  // The RAM output is already a register; gating it with the delayed read
  // strobe keeps pixel k on the core one cycle after its address, and forces
  // zeros once the reads stop (drain) or in idle.
  assign core_data = pix_valid ? mem_rdata : '0;

  assign crn_valid = (crn_level != '0);
  assign crn_x     = COORD_W'(head.x);
  assign crn_y     = COORD_W'(head.y);

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      core_ce   <= 1'b0;
      pix_valid <= 1'b0;
      drain_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      pix_valid <= mem_rd_en;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH;
            busy      <= 1'b1;
            mem_rd_en <= 1'b1;
            mem_addr  <= '0;
            overflow  <= 1'b0;
          end
        end
        FETCH: begin
          core_ce <= 1'b1;
          if (mem_addr == LAST_ADDR) begin
            state     <= DRAIN;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            drain_cnt <= '0;
          end else begin
            mem_addr <= mem_addr + 1'b1;
          end
        end
        DRAIN: begin
          // First drain cycle still carries the last real pixel.
          if (drain_cnt == LAST_DRAIN) begin
            state   <= DONE;
            core_ce <= 1'b0;
            done    <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef FAST_SEQ_CORNER_CNT_EN
  // Counts every offered corner, dropped or not; saturates.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      corner_count <= '0;
    end else if (push && (corner_count != '1)) begin
      corner_count <= corner_count + 1'b1;
    end
  end
`endif

  fast_corner_fifo #(
    .DEPTH (CRN_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (accept),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .head  (head),
    .full  (crn_full),
    .empty (crn_empty),
    .level (crn_level)
  );

endmodule

// File: tb/tb_fast_frame_sequencer.sv
// Self-checking bench for fast_frame_sequencer (8x4 frame, 40 drain cycles,
// 4-entry corner FIFO). A negedge monitor compares every output each cycle
// against a frame-timing formula and a queue model of the corner FIFO.
module tb_fast_frame_sequencer;

  localparam int unsigned IMG_COL   = 8;
  localparam int unsigned IMG_ROW   = 4;
  localparam int unsigned NPIX      = IMG_COL * IMG_ROW;
  localparam int unsigned DC        = 40;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned CW        = 10;
  localparam int          FRAME_LEN = NPIX + 2 + DC;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy, done, mem_rd_en, core_ce;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [7:0]        core_data;
  logic              core_iscorner;
  logic [CW-1:0]     core_x, core_y;
  logic              crn_valid, crn_ready;
  logic [CW-1:0]     crn_x, crn_y;
  logic              overflow;
`ifdef FAST_SEQ_CORNER_CNT_EN
  logic [19:0]       corner_count;
`endif

  always #5 clk = ~clk;

  fast_frame_sequencer #(
    .IMG_COL(IMG_COL), .IMG_ROW(IMG_ROW), .PIXEL_WIDTH(8), .COORD_W(CW),
    .ADDR_W(ADDR_W), .DRAIN_CYCLES(DC), .CRN_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .core_ce(core_ce), .core_data(core_data), .core_iscorner(core_iscorner),
    .core_x(core_x), .core_y(core_y), .crn_valid(crn_valid),
    .crn_ready(crn_ready), .crn_x(crn_x), .crn_y(crn_y), .overflow(overflow)
`ifdef FAST_SEQ_CORNER_CNT_EN
    , .corner_count(corner_count)
`endif
  );

  // Pixel RAM: pixel value is the low address byte.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= 8'(mem_addr);

  // Stub core: fires on chosen ce indices with x=idx-6, y=idx/8.
  int            ce_cnt = 0;
  logic [127:0]  fire_mask;
  logic          stub_mode;
  logic          rnd_corner;
  logic [CW-1:0] rnd_x, rnd_y;

  always @(posedge clk) begin
    if (rst || !busy) ce_cnt <= 0;
    else if (core_ce) ce_cnt <= ce_cnt + 1;
  end

  always_comb begin
    core_iscorner = rnd_corner;
    core_x        = rnd_x;
    core_y        = rnd_y;
    if (stub_mode) begin
      core_iscorner = core_ce && fire_mask[ce_cnt[6:0]];
      core_x        = CW'(ce_cnt - 6);
      core_y        = CW'(ce_cnt / 8);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endfunction

  // Reference model: frame timing from start cycle, FIFO as a queue.
  int                cyc = 0;
  int                t0 = -1;
  bit                mon_en = 1'b0;
  logic [2*CW-1:0]   q[$];
  bit                m_ovf = 1'b0;
  int                m_cnt = 0;
  int                rel;
  bit                e_busy, e_done, e_rd, e_ce, m_push, m_pop;
  int                e_data;

  always @(negedge clk) begin
    cyc++;
    rel    = (t0 < 0) ? -1 : cyc - t0;
    e_busy = (rel >= 1) && (rel <= FRAME_LEN);
    e_done = (rel == FRAME_LEN);
    e_rd   = (rel >= 1) && (rel <= int'(NPIX));
    e_ce   = (rel >= 2) && (rel <= int'(NPIX + 1 + DC));
    e_data = ((rel >= 2) && (rel <= int'(NPIX + 1))) ? rel - 2 : 0;
    if (mon_en) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("mem_rd_en", 32'(mem_rd_en), 32'(e_rd));
      if (e_rd) chk("mem_addr", 32'(mem_addr), 32'(rel - 1));
      chk("core_ce", 32'(core_ce), 32'(e_ce));
      chk("core_data", 32'(core_data), 32'(e_data));
      chk("crn_valid", 32'(crn_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("crn_head", 32'({crn_y, crn_x}), 32'(q[0]));
      chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef FAST_SEQ_CORNER_CNT_EN
      chk("corner_count", 32'(corner_count), 32'(m_cnt));
`endif
    end
    if (rst) begin
      t0 = -1; q.delete(); m_ovf = 1'b0; m_cnt = 0;
    end else if (start && !e_busy) begin
      t0 = cyc; q.delete(); m_ovf = 1'b0; m_cnt = 0;
    end else begin
      m_push = e_busy && core_iscorner;
      m_pop  = (q.size() != 0) && crn_ready;
      if (m_push && m_cnt < 20'hFFFFF) m_cnt++;
      if (m_pop) void'(q.pop_front());
      if (m_push) begin
        if (q.size() < DEPTH) q.push_back({core_y, core_x});
        else m_ovf = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame from an idle cycle; optional ready/start/rst pulses at
  // cycle offset k. Returns k of the done cycle (or of the post-reset cycle).
  task automatic run_frame(input int ready_at, input int pulse_at, input int rst_at, output int k);
    start = 1'b1;
    step();
    start = 1'b0;
    k = 1;
    while (done !== 1'b1 && k < FRAME_LEN + 20) begin
      crn_ready = (k == ready_at);
      start     = (k == pulse_at);
      rst       = (k == rst_at);
      step();
      k++;
      crn_ready = 1'b0;
      start     = 1'b0;
      if (rst) begin
        rst = 1'b0;
        return;
      end
    end
  endtask

  // Pops everything with ready held; returns entries popped.
  task automatic drain_fifo(output int n);
    n = 0;
    crn_ready = 1'b1;
    for (int j = 0; j < int'(DEPTH) + 2; j++) begin
      if (crn_valid === 1'b1) n++;
      step();
    end
    crn_ready = 1'b0;
  endtask

  typedef struct {
    string         nm;
    logic [127:0]  mask;
    bit            drain;
    int            exp_level;
    bit            exp_ovf;
    int            exp_cnt;
    logic [CW-1:0] hx;
    logic [CW-1:0] hy;
  } scen_t;

  scen_t tbl[4];

  initial begin
    int k, n;
    tbl[0] = '{"nominal",  128'd1 << 9, 1'b1, 1, 1'b0, 1, 10'd3, 10'd1};
    tbl[1] = '{"overflow", (128'd1 << 10) | (128'd1 << 12) | (128'd1 << 14) |
                           (128'd1 << 16) | (128'd1 << 18) | (128'd1 << 20),
                           1'b0, 4, 1'b1, 6, 10'd4, 10'd1};
    tbl[2] = '{"cleared",  128'd0, 1'b1, 0, 1'b0, 0, 10'd0, 10'd0};
    tbl[3] = '{"drain_crn", (128'd1 << 40) | (128'd1 << 71), 1'b1, 2, 1'b0, 2, 10'd34, 10'd5};

    rst = 1'b1; start = 1'b0; crn_ready = 1'b0; stub_mode = 1'b1;
    fire_mask = '0; rnd_corner = 1'b0; rnd_x = '0; rnd_y = '0;
    step(); step();
    mon_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_core_ce", 32'(core_ce), 32'd0);
    chk("rst_core_data", 32'(core_data), 32'd0);
    chk("rst_crn_valid", 32'(crn_valid), 32'd0);
    chk("rst_crn_x", 32'(crn_x), 32'd0);
    chk("rst_crn_y", 32'(crn_y), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    repeat (8) step();

    for (int i = 0; i < 4; i++) begin
      fire_mask = tbl[i].mask;
      run_frame(-1, -1, -1, k);
      chk({tbl[i].nm, "_done_lat"}, 32'(k), 32'(FRAME_LEN));
      step();
      chk({tbl[i].nm, "_busy_low"}, 32'(busy), 32'd0);
      chk({tbl[i].nm, "_valid"}, 32'(crn_valid), 32'(tbl[i].exp_level != 0));
      chk({tbl[i].nm, "_ovf"}, 32'(overflow), 32'(tbl[i].exp_ovf));
`ifdef FAST_SEQ_CORNER_CNT_EN
      chk({tbl[i].nm, "_cnt"}, 32'(corner_count), 32'(tbl[i].exp_cnt));
`endif
      if (tbl[i].exp_level != 0) begin
        chk({tbl[i].nm, "_head_x"}, 32'(crn_x), 32'(tbl[i].hx));
        chk({tbl[i].nm, "_head_y"}, 32'(crn_y), 32'(tbl[i].hy));
      end
      if (tbl[i].drain) begin
        drain_fifo(n);
        chk({tbl[i].nm, "_level"}, 32'(n), 32'(tbl[i].exp_level));
      end
    end

    // Full FIFO with simultaneous push and pop.
    fire_mask = 128'h1F << 10;
    run_frame(16, -1, -1, k);
    step();
    chk("fullpp_ovf", 32'(overflow), 32'd0);
    chk("fullpp_head_x", 32'(crn_x), 32'd5);
    drain_fifo(n);
    chk("fullpp_level", 32'(n), 32'd4);

    // Reset mid-frame at mem_addr 17, then a clean frame.
    fire_mask = 128'd1 << 8;
    run_frame(-1, -1, 18, k);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_core_ce", 32'(core_ce), 32'd0);
    chk("midrst_crn_valid", 32'(crn_valid), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    step();
    fire_mask = '0;
    run_frame(-1, -1, -1, k);
    chk("postrst_done_lat", 32'(k), 32'(FRAME_LEN));
    step();

    // Start pulse during busy is ignored.
    run_frame(-1, 6, -1, k);
    chk("busystart_done_lat", 32'(k), 32'(FRAME_LEN));
    step();

    // Start held through done: one-cycle busy gap, then a fresh frame.
    start = 1'b1;
    step();
    k = 1;
    while (done !== 1'b1 && k < FRAME_LEN + 20) begin step(); k++; end
    chk("b2b_first_lat", 32'(k), 32'(FRAME_LEN));
    step();
    chk("b2b_gap_busy", 32'(busy), 32'd0);
    step();
    chk("b2b_restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    k = 1;
    while (done !== 1'b1 && k < FRAME_LEN + 20) begin step(); k++; end
    chk("b2b_second_lat", 32'(k), 32'(FRAME_LEN));
    step();

    // Random traffic against the model.
    stub_mode = 1'b0;
    for (int i = 0; i < 900; i++) begin
      rnd_corner = ($urandom_range(0, 2) == 0);
      rnd_x      = CW'($urandom);
      rnd_y      = CW'($urandom);
      crn_ready  = ($urandom_range(0, 2) == 0);
      start      = ($urandom_range(0, 15) == 0);
      rst        = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; start = 1'b0; crn_ready = 1'b0; rnd_corner = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
